// File: rtl/dom_and_pipe.sv
// Order-D domain-oriented masked AND over W parallel lanes.
// Stage 1 registers reshared partial products; stage 2 compresses per domain.
module dom_and_pipe #(
    parameter int D = 1,
    parameter int W = 1,
    localparam int N = D + 1,
    localparam int R = D * (D + 1) / 2
) (
    input  logic           clock_0,
    input  logic           reset_0,
    input  logic           io_en,
    input  logic           io_in_valid,
    input  logic [N*W-1:0] io_i0,
    input  logic [N*W-1:0] io_i1,
    input  logic [R*W-1:0] p_rand,
    output logic [N*W-1:0] io_o0,
    output logic           io_out_valid
);

    function automatic int pair_idx(input int i, input int j);
        return i * N - i * (i + 1) / 2 + (j - i - 1);
    endfunction

    logic [N*N*W-1:0] t_q, t_d;
    logic [N*W-1:0]   o_q, o_d;
    logic             v1_q, v1_d;
    logic             ov_q, ov_d;
    logic [W-1:0]     acc;

    always_comb begin
        t_d  = t_q;
        o_d  = o_q;
        v1_d = v1_q;
        ov_d = ov_q;
        acc  = '0;
        if (io_en) begin
            // Each term t[i][j] is flopped on its own: the glitch barrier
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (i == j) begin
                        t_d[(i*N+j)*W +: W] = io_i0[i*W +: W] & io_i1[j*W +: W];
                    end else begin
                        t_d[(i*N+j)*W +: W] = (io_i0[i*W +: W] & io_i1[j*W +: W])
                            ^ p_rand[pair_idx(i < j ? i : j, i < j ? j : i)*W +: W];
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                acc = '0;
                for (int j = 0; j < N; j++) begin
                    acc = acc ^ t_q[(i*N+j)*W +: W];
                end
                o_d[i*W +: W] = acc;
            end
            v1_d = io_in_valid;
            ov_d = v1_q;
        end
    end

    always_ff @(posedge clock_0 or negedge reset_0) begin
        if (!reset_0) begin
            t_q  <= '0;
            o_q  <= '0;
            v1_q <= 1'b0;
            ov_q <= 1'b0;
        end else begin
            t_q  <= t_d;
            o_q  <= o_d;
            v1_q <= v1_d;
            ov_q <= ov_d;
        end
    end

    assign io_o0        = o_q;
    assign io_out_valid = ov_q;

endmodule

// File: doc/dom_and_pipe.md
# dom_and_pipe

Parametrised domain-oriented-masking (DOM) AND gate of arbitrary protection order `D` over `W` independent bit lanes. It computes the masked product of two `D+1`-share inputs with one register stage that separates the resharing from the compression, plus a valid pipeline and clock-enable stall. It is the successor of the first-order single-bit DOM AND used in the combined-random-model test designs. It serves as the nonlinear building block for higher-order masked S-boxes in the same flow.

## Interface
- `D`, default 1: masking order; share count `N = D+1`.
- `W`, default 1: independent bit lanes, all processed in parallel.
- Derived `R = D*(D+1)/2`: fresh random bits per lane.

Ports:
- `clock_0` input 1: single clock; all state is on the rising edge.
- `reset_0` input 1: asynchronous, active-low reset.
- `io_en` input 1: stage enable; 0 freezes every register.
- `io_in_valid` input 1: input shares are valid this cycle.
- `io_i0` input N*W: operand a; share s of lane b is at bit `s*W+b`.
- `io_i1` input N*W: operand b, same packing.
- `p_rand` input R*W: fresh randomness; pair k of lane b is at bit `k*W+b`.
- `io_o0` output N*W: product shares, same packing.
- `io_out_valid` output 1: `io_o0` holds a valid result.

## Operation
- Pair index for share pair i<j: `k = i*N - i*(i+1)/2 + (j-i-1)`. For D=2 the pairs map as (0,1)->0, (0,2)->1, (1,2)->2.
- Stage 1, per lane, registers N*N terms `t[i][j]`:
  - inner: `t[i][i] = a_i & b_i`
  - cross, for i≠j: `t[i][j] = (a_i & b_j) ^ r_k`, where k = pair(min(i,j), max(i,j)).
- Each `t[i][j]` has its own flop. Cross terms must never be combined before this register; this is the glitch barrier.
- Stage 2: `o_i = XOR over j of t[i][j]`, registered into `io_o0`.
- Valid pipeline: `v1 <= io_in_valid`, then `io_out_valid <= v1`.
- When `io_en=1`, all stages load every cycle, whether or not the input is valid. When `io_en=0`, all stage-1, output and valid flops hold.
- Functional invariant: XOR of the `io_o0` shares equals (XOR of the `io_i0` shares) AND (XOR of the `io_i1` shares), per lane. This holds for any value of `p_rand`.
- No share of `io_i0`/`io_i1` from domain i is combined with domain j≠i outside a stage-1 cross term.

## Timing
- Reset (`reset_0=0`, asynchronous): all stage-1 flops, `io_o0` and both valid flops clear to 0 immediately. `io_out_valid=0` during reset and on the first edge after release.
- Latency: the result appears exactly 2 enabled rising edges after the input is sampled. With `io_en` held at 1, inputs presented in cycle c appear in cycle c+2.
- Throughput: one operation per enabled cycle, with no bubbles.
- `p_rand` is sampled on the same edge as the input shares. It must be fresh for every enabled cycle; this is the caller's obligation and is not checked.
- Stall: if `io_en` drops, outputs stay stable for as many cycles as it stays low. The result then arrives after the remaining enabled edges.
- Reset mid-operation: in-flight data is discarded and `io_out_valid` goes to 0. There is no partial output.
- Simultaneous `io_en=0` and `io_in_valid=1`: the input is not captured. The caller must re-present it.

## Test plan
- D=1, W=1: a=(1,0), b=(0,1), r=1 with en=1, valid=1 → two cycles later `io_o0`=(0,1) (share0=0, share1=1), `io_out_valid=1`, unmasked value 1.
- D=2, W=4: 1000 random sharings with random `p_rand`, back-to-back → every output in cycle c+2 unmasks to (A&B) per lane. `io_out_valid` is a 2-cycle-delayed copy of `io_in_valid`.
- D=1, W=8 with `p_rand`=0 and then all-ones: A=0xA5, B=0x3C → unmasked result 0x24 in both cases. Individual share values differ between the two cases.
- Stall: issue an operation, hold `io_en=0` for 5 cycles after the first edge → outputs and `io_out_valid` are frozen. The result appears on the first enabled edge after `io_en` returns to 1.
- Reset: assert `reset_0` low mid-pipeline, asynchronously between edges → `io_o0`=0 and `io_out_valid`=0 immediately, before the next clock. After release, the first valid result comes only from inputs issued after release.
- Structural check: D=3 → the design has N*N*W = 16*W stage-1 flops. The combinational cone of each stage-1 flop depends on exactly one share from each operand.
